// File: rtl/data_mem_banked_if.sv
`default_nettype none
// ============================================================================
// data_mem_banked_if : write/read/zeroize bus of the banked data memory
// Rev 1.0
// ============================================================================
interface data_mem_banked_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int W_BYTES    = 2,
  parameter int R_BYTES    = 2
);
  logic                          we;
  logic [W_BYTES-1:0]            w_be;
  logic [ADDR_WIDTH-1:0]         w_addr;
  logic [W_BYTES*DATA_WIDTH-1:0] w_data;
  logic                          re;
  logic [ADDR_WIDTH-1:0]         r_addr;
  logic [R_BYTES*DATA_WIDTH-1:0] r_data;
  logic                          r_valid;
  logic                          clear;
  logic                          busy;

  modport master (
    output we, w_be, w_addr, w_data, re, r_addr, clear,
    input  r_data, r_valid, busy
  );

  modport slave (
    input  we, w_be, w_addr, w_data, re, r_addr, clear,
    output r_data, r_valid, busy
  );
endinterface
`default_nettype wire

// File: rtl/data_mem_banked.sv
`default_nettype none
// ============================================================================
// data_mem_banked : byte-lane memory, write-first bypass, built-in zeroize
// Rev 1.0
// ============================================================================
module data_mem_banked #(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 8,
  parameter int W_BYTES        = 2,
  parameter int R_BYTES        = 2,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic              clk,
  input  logic              reset,
  data_mem_banked_if.slave  bus
);

  localparam int c_DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   clr_addr;
  logic                    busy_int;

  logic [DATA_WIDTH-1:0]   mem [c_DEPTH];

  logic [ADDR_WIDTH-1:0]   w_lane_addr [W_BYTES];
  logic [DATA_WIDTH-1:0]   w_lane_data [W_BYTES];
  logic [ADDR_WIDTH-1:0]   r_lane_addr [R_BYTES];
  logic [DATA_WIDTH-1:0]   rd_byte     [R_BYTES];
  logic [R_BYTES*DATA_WIDTH-1:0] rd_next;

  assign busy_int = (state == CLEAR);
  assign bus.busy = busy_int;

  for (genvar i = 0; i < W_BYTES; i++) begin : g_wlane
    assign w_lane_addr[i] = bus.w_addr + ADDR_WIDTH'(i);
    assign w_lane_data[i] = bus.w_data[i*DATA_WIDTH +: DATA_WIDTH];
  end

  for (genvar j = 0; j < R_BYTES; j++) begin : g_rlane
    assign r_lane_addr[j]                      = bus.r_addr + ADDR_WIDTH'(j);
    assign rd_next[j*DATA_WIDTH +: DATA_WIDTH] = rd_byte[j];
  end

  // Zeroize sequencer: one byte per cycle, ignores clear while running
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;
      clr_addr <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.clear) begin
            state    <= CLEAR;
            clr_addr <= '0;
          end
        end
        CLEAR: begin
          clr_addr <= clr_addr + ADDR_WIDTH'(1);
          if (clr_addr == {ADDR_WIDTH{1'b1}}) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Array has no reset; only the zeroize engine or user writes change it
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (busy_int) begin
        mem[clr_addr] <= '0;
      end else if (bus.we) begin
        for (int i = 0; i < W_BYTES; i++) begin
          if (bus.w_be[i]) begin
            mem[w_lane_addr[i]] <= w_lane_data[i];
          end
        end
      end
    end
  end

  // Per-lane write-first bypass: an enabled write lane hitting a read lane wins
  always_comb begin
    for (int j = 0; j < R_BYTES; j++) begin
      rd_byte[j] = mem[r_lane_addr[j]];
      for (int i = 0; i < W_BYTES; i++) begin
        if (bus.we && bus.w_be[i] && (w_lane_addr[i] == r_lane_addr[j])) begin
          rd_byte[j] = w_lane_data[i];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.r_data  <= '0;
      bus.r_valid <= 1'b0;
    end else begin
      bus.r_valid <= bus.re && !busy_int;
      if (bus.re && !busy_int) begin
        bus.r_data <= rd_next;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_data_mem_banked.sv
`default_nettype none
// ============================================================================
// tb_data_mem_banked : vector table + read scoreboard for data_mem_banked
// Rev 1.0
// ============================================================================
module tb_data_mem_banked;

  localparam int DW = 8;
  localparam int AW = 8;
  localparam int WB = 2;
  localparam int RB = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  data_mem_banked_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .W_BYTES(WB), .R_BYTES(RB)) bus ();

  data_mem_banked #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .W_BYTES(WB), .R_BYTES(RB), .CLEAR_ON_RESET(1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic        we;
    logic [1:0]  be;
    logic [7:0]  waddr;
    logic [15:0] wdata;
    logic        re;
    logic [7:0]  raddr;
    logic [15:0] exp;
  } vec_t;

  typedef struct {
    logic [15:0] data;
    int          due;
  } exp_t;

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  exp_t exp_q[$];
  vec_t vecs[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, req, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Each accepted read must show up exactly one edge later; any other valid is an error
  always @(negedge clk) begin : mon
    exp_t e;
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      e = exp_q.pop_front();
      check("r_valid", {31'b0, bus.r_valid}, 32'd1);
      check("r_data", {16'b0, bus.r_data}, {16'b0, e.data});
    end else begin
      check("r_valid_idle", {31'b0, bus.r_valid}, 32'd0);
    end
  end

  task automatic idle_inputs();
    bus.we = 1'b0; bus.w_be = '0; bus.w_addr = '0; bus.w_data = '0;
    bus.re = 1'b0; bus.r_addr = '0; bus.clear = 1'b0;
  endtask

  task automatic drive(input vec_t v);
    bus.we = v.we; bus.w_be = v.be; bus.w_addr = v.waddr; bus.w_data = v.wdata;
    bus.re = v.re; bus.r_addr = v.raddr;
    if (v.re) exp_q.push_back('{data: v.exp, due: cyc + 1});
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic rd(input logic [7:0] a, input logic [15:0] e);
    drive('{1'b0, 2'b00, 8'h00, 16'h0000, 1'b1, a, e});
  endtask

  task automatic wr(input logic [7:0] a, input logic [15:0] d);
    drive('{1'b1, 2'b11, a, d, 1'b0, 8'h00, 16'h0000});
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (bus.busy === 1'b1 && n < 2000) begin
      n++;
      @(negedge clk);
    end
  endtask

  initial begin
    int n;
    vecs[0]  = '{1'b0, 2'b00, 8'h00, 16'h0000, 1'b1, 8'h10, 16'h0000};
    vecs[1]  = '{1'b1, 2'b11, 8'h10, 16'hBEEF, 1'b0, 8'h00, 16'h0000};
    vecs[2]  = '{1'b0, 2'b00, 8'h00, 16'h0000, 1'b1, 8'h10, 16'hBEEF};
    vecs[3]  = '{1'b0, 2'b00, 8'h00, 16'h0000, 1'b1, 8'h11, 16'h00BE};
    vecs[4]  = '{1'b1, 2'b10, 8'h10, 16'h1234, 1'b0, 8'h00, 16'h0000};
    vecs[5]  = '{1'b0, 2'b00, 8'h00, 16'h0000, 1'b1, 8'h10, 16'h12EF};
    vecs[6]  = '{1'b0, 2'b11, 8'h10, 16'hFFFF, 1'b1, 8'h10, 16'h12EF};
    vecs[7]  = '{1'b1, 2'b11, 8'hFF, 16'hA55A, 1'b0, 8'h00, 16'h0000};
    vecs[8]  = '{1'b0, 2'b00, 8'h00, 16'h0000, 1'b1, 8'h00, 16'h00A5};
    vecs[9]  = '{1'b0, 2'b00, 8'h00, 16'h0000, 1'b1, 8'hFF, 16'hA55A};
    vecs[10] = '{1'b1, 2'b11, 8'h20, 16'h7788, 1'b0, 8'h00, 16'h0000};
    vecs[11] = '{1'b1, 2'b01, 8'h20, 16'h1111, 1'b1, 8'h20, 16'h7711};
    vecs[12] = '{1'b0, 2'b00, 8'h00, 16'h0000, 1'b1, 8'h20, 16'h7711};
    vecs[13] = '{1'b1, 2'b11, 8'h31, 16'hCCDD, 1'b1, 8'h30, 16'hDD00};
    vecs[14] = '{1'b0, 2'b00, 8'h00, 16'h0000, 1'b1, 8'h31, 16'hCCDD};
    vecs[15] = '{1'b1, 2'b10, 8'hFF, 16'h0000, 1'b1, 8'hFF, 16'h005A};

    reset = 1'b1;
    idle_inputs();
    @(negedge clk);
    check("reset_busy", {31'b0, bus.busy}, 32'd1);
    check("reset_r_data", {16'b0, bus.r_data}, 32'd0);
    reset = 1'b0;
    count_busy(n);
    check("reset_busy_len", n, 32'd256);

    for (int k = 0; k < 16; k++) drive(vecs[k]);
    @(negedge clk);
    @(negedge clk);
    check("r_data_hold", {16'b0, bus.r_data}, 32'h005A);

    // Clear with a read, a second clear and a write issued while busy
    bus.clear = 1'b1;
    @(negedge clk);
    bus.clear = 1'b0;
    n = 0;
    while (bus.busy === 1'b1 && n < 2000) begin
      bus.re = (n == 5);     bus.r_addr = 8'h10;
      bus.clear = (n == 10);
      bus.we = (n == 200);   bus.w_be = 2'b11; bus.w_addr = 8'h40; bus.w_data = 16'h5555;
      n++;
      @(negedge clk);
    end
    idle_inputs();
    check("clear_busy_len", n, 32'd256);
    check("clear_r_data_held", {16'b0, bus.r_data}, 32'h005A);
    rd(8'h40, 16'h0000);
    rd(8'h10, 16'h0000);

    // Reset in the middle of a clear restarts the full sweep
    wr(8'h50, 16'h9999);
    rd(8'h50, 16'h9999);
    @(negedge clk);
    bus.clear = 1'b1;
    @(negedge clk);
    bus.clear = 1'b0;
    for (int k = 0; k < 100; k++) @(negedge clk);
    check("busy_before_reset", {31'b0, bus.busy}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midclear_reset_r_data", {16'b0, bus.r_data}, 32'd0);
    count_busy(n);
    check("restart_busy_len", n, 32'd256);

    rd(8'h10, 16'h0000);
    rd(8'h20, 16'h0000);
    rd(8'h30, 16'h0000);
    rd(8'h50, 16'h0000);
    rd(8'hFF, 16'h0000);
    rd(8'h40, 16'h0000);
    @(negedge clk);
    @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/data_mem_banked.md
# data_mem_banked

Parametrised byte-addressed data memory for the matrix-multiplier core, succeeding the fixed 8-bit / 16-bit-write data memory. It supports independent, simultaneous multi-byte write and read ports, per-byte write enables, and wrap-around addressing. Same-cycle reads see written bytes (write-first). A built-in zeroize engine clears the whole array after reset or on request. It sits between the core's load/store unit and the matrix operand/result storage.

## Interface
- DATA_WIDTH, 8, bits per addressable byte lane
- ADDR_WIDTH, 8, byte address width; depth = 2**ADDR_WIDTH
- W_BYTES, 2, lanes per write beat (1 ≤ W_BYTES ≤ 2**ADDR_WIDTH)
- R_BYTES, 2, lanes per read beat (1 ≤ R_BYTES ≤ 2**ADDR_WIDTH)
- CLEAR_ON_RESET, 1, 1 = run zeroize after every reset; 0 = contents untouched by reset

- clk  in  1  single clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- we  in  1  write strobe
- w_be  in  W_BYTES  per-lane write enable, bit i ↔ w_data lane i
- w_addr  in  ADDR_WIDTH  byte address of lane 0
- w_data  in  W_BYTES*DATA_WIDTH  lane i = bits [(i+1)*DATA_WIDTH-1 : i*DATA_WIDTH]
- re  in  1  read strobe
- r_addr  in  ADDR_WIDTH  byte address of lane 0
- r_data  out  R_BYTES*DATA_WIDTH  registered read data, little-endian lanes
- r_valid  out  1  r_data updated this cycle
- clear  in  1  single-cycle request to zeroize the array
- busy  out  1  zeroize in progress; user ports ignored

## Operation
- Storage: 2**ADDR_WIDTH entries of DATA_WIDTH bits. The reset signal never initialises the array; only zeroize does.
- Write: when we=1 and busy=0, each lane i with w_be[i]=1 writes mem[(w_addr+i) mod 2**ADDR_WIDTH] = lane i. Lanes with w_be[i]=0 leave their byte unchanged.
- Read: when re=1 and busy=0, lane j of r_data is loaded with mem[(r_addr+j) mod 2**ADDR_WIDTH]. r_data holds its value when re=0.
- Read and write are independent. Both may fire in the same cycle; a write never blocks a read.
- Read-during-write, per byte: if a read lane addresses a byte being written in the same cycle with its enable set, that lane returns the new value. All other lanes return the stored value.
- Zeroize FSM has two states, IDLE and CLEAR, and a counter clr_addr of ADDR_WIDTH bits.
  - reset=1 → state = CLEAR if CLEAR_ON_RESET else IDLE; clr_addr = 0.
  - IDLE & clear=1 → CLEAR, clr_addr = 0.
  - CLEAR: each cycle writes 0 to mem[clr_addr] and increments clr_addr. When clr_addr = 2**ADDR_WIDTH-1, the FSM writes that byte and returns to IDLE.
  - clear while in CLEAR is ignored; it does not restart.
  - reset mid-CLEAR restarts from address 0 (or aborts, if CLEAR_ON_RESET=0).
- busy = (state == CLEAR). While busy=1, we and re are ignored, and r_data/r_valid keep their reset/held values with r_valid=0.

## Timing
- Reset values: r_data = 0, r_valid = 0. busy = 1 in the cycle after reset is sampled if CLEAR_ON_RESET=1, otherwise 0.
- Write latency: data written at edge N is readable by a read issued at edge N, via bypass, and later.
- Read latency: 1 cycle. re sampled at edge N → r_data valid and r_valid = 1 after edge N. r_valid is a 1-cycle pulse per accepted read and is 0 on cycles without an accepted read.
- Zeroize duration: busy is high for exactly 2**ADDR_WIDTH cycles (256 at defaults). The first user access is accepted in the cycle busy reads 0.
- Back-to-back reads and writes are accepted every cycle; there is no backpressure other than busy.
- reset has priority over clear, we and re in the same cycle.

## Test plan
- Reset with CLEAR_ON_RESET=1:
  - busy is high for 256 cycles then falls.
  - A read at 0x10 → r_data = 0x0000, with r_valid high one cycle later.
- Full write then read:
  - Write w_addr=0x10, w_data=0xBEEF, w_be=2'b11.
  - Next cycle, read 0x10 → r_data = 0xBEEF.
  - Read 0x11 → r_data = 0x00BE.
- Byte enable:
  - Over 0xBEEF at 0x10, write 0x1234 with w_be=2'b10.
  - Read 0x10 → 0x12EF.
- Wrap-around:
  - Write 0xA55A at w_addr=0xFF.
  - Read 0x00 → low byte 0xA5.
  - Read 0xFF → 0xA55A.
- Read-during-write:
  - Set mem[0x20..0x21] = 0x7788.
  - In the same cycle, write 0x1111 with w_be=2'b01 and read 0x20 → r_data = 0x7711.
- Zeroize control:
  - Pulse clear after data is loaded; busy is high for 256 cycles.
  - A re issued at cycle 5 of the clear gives r_valid = 0, and a second clear at cycle 10 is ignored.
  - A reset at cycle 100 restarts the full 256-cycle clear.
  - Afterwards, all previously written addresses read 0.
